mult_div_unit: RTL and testbench

//  Multi-cycle MULT/MULTU/DIV/DIVU engine that runs beside the single-cycle ALU.

---
 rtl/mult_div_unit_if.sv | 37 +++
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Bundles the request, status and HI/LO signals of the multiply/divide unit.
//   master : pipeline side, drives operation requests and MTHI/MTLO writes
//   slave  : the mult_div_unit itself
// Signals
//   start      begin an operation (accepted only while idle)
//   op[1:0]    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       rs / rt operands
//   wrhi/wrlo  MTHI / MTLO write strobes, data on wdat
//   busy       operation in flight
//   done       one-cycle pulse when HI/LO hold a fresh result
//   dz         divide-by-zero flag, valid with done
//   hi, lo     architectural HI / LO registers
interface mult_div_unit_if #(parameter int SIZE = 32);
  logic            start;
  logic [1:0]      op;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            wrhi;
  logic            wrlo;
  logic [SIZE-1:0] wdat;
  logic            busy;
  logic            done;
  logic            dz;
  logic [SIZE-1:0] hi;
  logic [SIZE-1:0] lo;

  modport master (
    output start, op, a, b, wrhi, wrlo, wdat,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, wrhi, wrlo, wdat,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle MULT/MULTU/DIV/DIVU engine running beside the ALU. Owns HI/LO,
//   serves MTHI/MTLO writes, and produces one result bit per cycle using
//   shift-add multiply and restoring divide on unsigned magnitudes, with the
//   sign fixed up in a final cycle.
// Ports
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset; aborts any operation in flight
//   bus  mult_div_unit_if.slave (start/op/a/b/wrhi/wrlo/wdat in,
//        busy/done/dz/hi/lo out)
module mult_div_unit #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  mult_div_unit_if.slave    bus
);

  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            sign_a;
  logic            sign_b;
  // acc: multiply accumulator / divide partial remainder
  // mplier: multiplier (low product half) / dividend shifting into quotient
  // mcand: multiplicand / divisor
  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] mplier;
  logic [SIZE-1:0] mcand;
  logic [SIZE-1:0] hi_q;
  logic [SIZE-1:0] lo_q;
  logic            done_q;
  logic            dz_q;

  // Operand sign and magnitude; only signed ops (op[0]==0) strip the sign.
  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [SIZE-1:0] a_mag;
  logic [SIZE-1:0] b_mag;

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.a[SIZE-1];
  assign b_neg     = signed_op & bus.b[SIZE-1];
  assign a_mag     = a_neg ? (SIZE'(0) - bus.a) : bus.a;
  assign b_mag     = b_neg ? (SIZE'(0) - bus.b) : bus.b;

  // Multiply step: the add is one bit wider so its carry shifts back into acc.
  logic [SIZE:0]   mul_sum;
  assign mul_sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(SIZE+1){1'b0}});

  // Restoring divide step on the shifted partial remainder.
  logic [SIZE:0]   div_trial;
  logic            div_ge;
  logic [SIZE-1:0] rem_next;
  assign div_trial = {acc, mplier[SIZE-1]};
  assign div_ge    = div_trial >= {1'b0, mcand};
  assign rem_next  = div_ge ? SIZE'(div_trial - {1'b0, mcand}) : div_trial[SIZE-1:0];

  // Sign fix-up applied in FIX. With a zero divisor every step subtracts
  // nothing, so the remainder ends equal to |A| and rem_fix restores A itself.
  logic [2*SIZE-1:0] product;
  logic [2*SIZE-1:0] prod_fix;
  logic [SIZE-1:0]   quot_fix;
  logic [SIZE-1:0]   rem_fix;
  logic              div_zero;
  assign product  = {acc, mplier};
  assign prod_fix = (sign_a ^ sign_b) ? ((2*SIZE)'(0) - product) : product;
  assign quot_fix = (sign_a ^ sign_b) ? (SIZE'(0) - mplier) : mplier;
  assign rem_fix  = sign_a ? (SIZE'(0) - acc) : acc;
  assign div_zero = (mcand == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: IDLE -> RUN for SIZE cycles -> FIX for one cycle -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = done_q;
    bus.dz   = dz_q;
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end

  // Datapath: operand capture, iteration, result write-back and HI/LO writes.
  // HI/LO writes are only honoured when idle and no start is present.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[1];
            sign_a <= a_neg;
            sign_b <= b_neg;
            acc    <= '0;
            cnt    <= CW'(SIZE - 1);
            if (bus.op[1]) begin
              mplier <= a_mag;
              mcand  <= b_mag;
            end else begin
              mplier <= b_mag;
              mcand  <= a_mag;
            end
          end else begin
            if (bus.wrhi) hi_q <= bus.wdat;
            if (bus.wrlo) lo_q <= bus.wdat;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc    <= rem_next;
            mplier <= {mplier[SIZE-2:0], div_ge};
          end else begin
            acc    <= mul_sum[SIZE:1];
            mplier <= {mul_sum[0], mplier[SIZE-1:1]};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            dz_q <= div_zero;
            hi_q <= rem_fix;
            lo_q <= div_zero ? '1 : quot_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: directed vectors, randomized
//   multiply/divide against a plain-arithmetic reference model, divide by
//   zero, back-to-back ops, HI/LO writes and mid-operation reset.
module tb_mult_div_unit;

  localparam int SIZE = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_div_unit_if #(.SIZE(SIZE)) bus ();

  mult_div_unit #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Bench's own view of the architectural HI/LO.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  logic [31:0] edge_vals [6];

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
          up = ua / ub; lo = up[31:0];
          up = ua % ub; hi = up[31:0];
        end
      end
    endcase
  endtask

  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  // Called at the negedge of the cycle in which start is driven (cycle 0);
  // returns at the negedge of the DONE cycle and updates the model HI/LO.
  task automatic wait_done(input string name, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_hi, e_lo;
    logic e_dz;
    bit seen;
    model(op, a, b, e_hi, e_lo, e_dz);
    seen = 0;
    for (int cyc = 1; cyc <= 50 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.wrhi  = 1'b0;
        bus.wrlo  = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo) begin
          errors++;
          $display("[TB] FAIL %s busy/hold c1: busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                   name, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
      end
      if (cyc == 17) begin
        checks++;
        if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s hold mid-run: hi=%h lo=%h done=%b want hi=%h lo=%h done=0",
                   name, bus.hi, bus.lo, bus.done, m_hi, m_lo);
        end
      end
      if (bus.done === 1'b1) begin
        seen = 1;
        checks++;
        if (cyc != 34 || bus.hi !== e_hi || bus.lo !== e_lo || bus.dz !== e_dz) begin
          errors++;
          $display("[TB] FAIL %s result: cyc=%0d hi=%h lo=%h dz=%b want cyc=34 hi=%h lo=%h dz=%b",
                   name, cyc, bus.hi, bus.lo, bus.dz, e_hi, e_lo, e_dz);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: done not seen in 50 cycles, want done at 34", name);
    end
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  // One complete op followed by a check that DONE/DZ are one-cycle pulses.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive_start(op, a, b);
    wait_done(name, op, a, b);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.dz !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s pulse: done=%b dz=%b busy=%b want 0 0 0",
               name, bus.done, bus.dz, bus.busy);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dz !== 1'b0 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
               bus.busy, bus.done, bus.dz, bus.hi, bus.lo);
    end
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_directed();
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFF9, 32'd3);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100",  2'b11, 32'd100, 32'd7);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
  endtask

  task automatic test_random_mul();
    for (int i = 0; i < 12; i++)
      run_op("rand_mul", 2'($urandom_range(0, 1)), pick_operand(), pick_operand());
  endtask

  task automatic test_random_div();
    for (int i = 0; i < 12; i++)
      run_op("rand_div", 2'($urandom_range(2, 3)), pick_operand(), pick_operand());
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom(); b1 = $urandom();
    a2 = $urandom(); b2 = $urandom_range(1, 1000);
    @(negedge clk);
    drive_start(2'b00, a1, b1);
    wait_done("b2b_first", 2'b00, a1, b1);
    drive_start(2'b11, a2, b2);
    wait_done("b2b_second", 2'b11, a2, b2);
    @(negedge clk);
  endtask

  task automatic test_writes();
    @(negedge clk);
    bus.wrhi = 1'b1; bus.wrlo = 1'b1; bus.wdat = 32'hCAFE_F00D;
    @(negedge clk);
    bus.wrhi = 1'b0; bus.wrlo = 1'b0;
    m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      errors++;
      $display("[TB] FAIL write_both: hi=%h lo=%h want %h %h", bus.hi, bus.lo, m_hi, m_lo);
    end
    bus.wrhi = 1'b1; bus.wdat = 32'h0BAD_BEEF;
    @(negedge clk);
    bus.wrhi = 1'b0;
    m_hi = 32'h0BAD_BEEF;
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      errors++;
      $display("[TB] FAIL write_hi: hi=%h lo=%h want %h %h", bus.hi, bus.lo, m_hi, m_lo);
    end
    // START with WRLO: the write must be dropped and the op must run.
    drive_start(2'b11, 32'd1000, 32'd9);
    bus.wrlo = 1'b1; bus.wdat = 32'h1111_1111;
    wait_done("start_wrlo", 2'b11, 32'd1000, 32'd9);
    @(negedge clk);
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.wrhi = 1'b1; bus.wrlo = 1'b1; bus.wdat = 32'h5555_AAAA;
    @(negedge clk);
    bus.wrhi = 1'b0; bus.wrlo = 1'b0;
    m_hi = 32'h5555_AAAA; m_lo = 32'h5555_AAAA;
    drive_start(2'b00, 32'd12345, 32'd678);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.wrhi = 1'b0;
      if (cyc == 5) begin
        drive_start(2'b01, 32'hFFFF_FFFF, 32'd2);
        bus.wrhi = 1'b1; bus.wdat = 32'h7777_7777;
      end
      if (cyc == 6) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo) begin
          errors++;
          $display("[TB] FAIL busy_ignore: busy=%b hi=%h lo=%h want 1 %h %h",
                   bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
      end
      if (cyc == 10) rst = 1'b1;
      if (cyc == 11) rst = 1'b0;
    end
    m_hi = '0; m_lo = '0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    begin
      int done_count = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        if (bus.done === 1'b1) done_count++;
      end
      checks++;
      if (done_count != 0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
        errors++;
        $display("[TB] FAIL abort_no_done: done pulses=%0d hi=%h lo=%h want 0 0 0",
                 done_count, bus.hi, bus.lo);
      end
    end
  endtask

  initial begin
    edge_vals[0] = 32'h0000_0000;
    edge_vals[1] = 32'h0000_0001;
    edge_vals[2] = 32'hFFFF_FFFF;
    edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'h7FFF_FFFF;
    edge_vals[5] = 32'h8000_0001;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.wrhi = 1'b0; bus.wrlo = 1'b0; bus.wdat = '0;
    m_hi = '0; m_lo = '0;

    test_reset();
    test_directed();
    test_div_zero();
    test_random_mul();
    test_random_div();
    test_back_to_back();
    test_writes();
    test_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
